// File: rtl/udma_l2_wr_arb.sv
// L2 write-port arbiter for the uDMA RX channels: round-robin with burst hold,
// feeding a single registered output slot that is refilled in the same cycle it drains.
module udma_l2_wr_arb #(
  parameter int N_REQ         = 4,
  parameter int BURST_MAX     = 4,
  parameter int L2_DATA_WIDTH = 32
) (
  input  logic                             sys_clk_i,
  input  logic                             sys_resetn_i,
  input  logic [N_REQ-1:0]                 in_req_i,
  input  logic [N_REQ*32-1:0]              in_addr_i,
  input  logic [N_REQ*L2_DATA_WIDTH-1:0]   in_wdata_i,
  input  logic [N_REQ*L2_DATA_WIDTH/8-1:0] in_be_i,
  output logic [N_REQ-1:0]                 in_gnt_o,
  output logic                             L2_wo_req_o,
  input  logic                             L2_wo_gnt_i,
  output logic [31:0]                      L2_wo_addr_o,
  output logic [L2_DATA_WIDTH-1:0]         L2_wo_wdata_o,
  output logic [L2_DATA_WIDTH/8-1:0]       L2_wo_be_o,
  output logic                             busy_o
);

  localparam int BE_W  = L2_DATA_WIDTH / 8;
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         last_q, last_d;
  logic [3:0]               burst_cnt_q, burst_cnt_d;
  logic [31:0]              addr_q, addr_d;
  logic [L2_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]          be_q, be_d;

  logic [31:0]              addr_arr  [N_REQ];
  logic [L2_DATA_WIDTH-1:0] wdata_arr [N_REQ];
  logic [BE_W-1:0]          be_arr    [N_REQ];

  logic             any_req;
  logic             hold;
  logic             found;
  logic             acc;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = in_addr_i[g*32 +: 32];
    assign wdata_arr[g] = in_wdata_i[g*L2_DATA_WIDTH +: L2_DATA_WIDTH];
    assign be_arr[g]    = in_be_i[g*BE_W +: BE_W];
  end

  // burst_cnt of zero means no grant since reset, so last is not yet a real
  // previous winner and must not be held; this gives requester 0 first priority.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    any_req = |in_req_i;
    hold    = in_req_i[last_q] && (burst_cnt_q != 4'd0) && (burst_cnt_q < 4'(BURST_MAX));
    win_idx = last_q;
    found   = 1'b0;
    cand    = '0;
    if (!hold) begin
      for (int i = 1; i <= N_REQ; i++) begin
        cand = IDX_W'((int'(last_q) + i) % N_REQ);
        if (!found && in_req_i[cand]) begin
          win_idx = cand;
          found   = 1'b1;
        end
      end
    end
    acc = sys_resetn_i && any_req && ((state_q == ST_EMPTY) || L2_wo_gnt_i);
    in_gnt_o = '0;
    if (acc) begin
      in_gnt_o[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    if (acc) begin
      state_d = ST_FULL;
      addr_d  = addr_arr[win_idx];
      wdata_d = wdata_arr[win_idx];
      be_d    = be_arr[win_idx];
      last_d  = win_idx;
      // A repeat win past the burst limit (sole requester) starts a fresh burst.
      if ((win_idx == last_q) && (burst_cnt_q < 4'(BURST_MAX))) begin
        burst_cnt_d = burst_cnt_q + 4'd1;
      end else begin
        burst_cnt_d = 4'd1;
      end
    end else if ((state_q == ST_FULL) && L2_wo_gnt_i) begin
      state_d = ST_EMPTY;
    end
  end

  // NOTE: the payload registers are reset too, so the L2 bus shows zeros rather than stale data after reset.
  always_ff @(posedge sys_clk_i or negedge sys_resetn_i) begin
    if (!sys_resetn_i) begin
      state_q     <= ST_EMPTY;
      last_q      <= IDX_W'(N_REQ - 1);
      burst_cnt_q <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
    end
  end

  assign L2_wo_req_o   = (state_q == ST_FULL);
  assign L2_wo_addr_o  = addr_q;
  assign L2_wo_wdata_o = wdata_q;
  assign L2_wo_be_o    = be_q;
  assign busy_o        = (state_q == ST_FULL) || any_req;

endmodule

// File: tb/tb_udma_l2_wr_arb.sv
// Directed bench for udma_l2_wr_arb: three instances with BURST_MAX 4, 2 and 1
// share one stimulus stream; each scenario checks the instance it targets.
module tb_udma_l2_wr_arb;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] addr_flat;
  logic [127:0] wdata_flat;
  logic [15:0]  be_flat;
  logic         l2_gnt;

  logic [3:0]  gnt4, gnt2, gnt1;
  logic        l2req4, l2req2, l2req1;
  logic [31:0] addr4, addr2, addr1;
  logic [31:0] wdata4, wdata2, wdata1;
  logic [3:0]  be4, be2, be1;
  logic        busy4, busy2, busy1;

  logic [31:0] addr_tab  [4];
  logic [31:0] wdata_tab [4];
  logic [3:0]  be_tab    [4];

  int n_vec;
  int n_err;

  udma_l2_wr_arb #(.N_REQ(4), .BURST_MAX(4), .L2_DATA_WIDTH(32)) u_b4 (
    .sys_clk_i(clk), .sys_resetn_i(rst_n), .in_req_i(req), .in_addr_i(addr_flat),
    .in_wdata_i(wdata_flat), .in_be_i(be_flat), .in_gnt_o(gnt4), .L2_wo_req_o(l2req4),
    .L2_wo_gnt_i(l2_gnt), .L2_wo_addr_o(addr4), .L2_wo_wdata_o(wdata4),
    .L2_wo_be_o(be4), .busy_o(busy4)
  );

  udma_l2_wr_arb #(.N_REQ(4), .BURST_MAX(2), .L2_DATA_WIDTH(32)) u_b2 (
    .sys_clk_i(clk), .sys_resetn_i(rst_n), .in_req_i(req), .in_addr_i(addr_flat),
    .in_wdata_i(wdata_flat), .in_be_i(be_flat), .in_gnt_o(gnt2), .L2_wo_req_o(l2req2),
    .L2_wo_gnt_i(l2_gnt), .L2_wo_addr_o(addr2), .L2_wo_wdata_o(wdata2),
    .L2_wo_be_o(be2), .busy_o(busy2)
  );

  udma_l2_wr_arb #(.N_REQ(4), .BURST_MAX(1), .L2_DATA_WIDTH(32)) u_b1 (
    .sys_clk_i(clk), .sys_resetn_i(rst_n), .in_req_i(req), .in_addr_i(addr_flat),
    .in_wdata_i(wdata_flat), .in_be_i(be_flat), .in_gnt_o(gnt1), .L2_wo_req_o(l2req1),
    .L2_wo_gnt_i(l2_gnt), .L2_wo_addr_o(addr1), .L2_wo_wdata_o(wdata1),
    .L2_wo_be_o(be1), .busy_o(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic load_payload();
    for (int i = 0; i < 4; i++) begin
      addr_flat[i*32 +: 32]  = addr_tab[i];
      wdata_flat[i*32 +: 32] = wdata_tab[i];
      be_flat[i*4 +: 4]      = be_tab[i];
    end
  endtask

  // Leaves time at posedge+2: inputs are driven here, checks follow after #2.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n  = 1'b0;
    req    = 4'b0000;
    l2_gnt = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int seq_burst [9];
    int seq_rr    [7];
    logic [31:0] old_addr;
    logic [31:0] old_data;

    n_vec = 0;
    n_err = 0;
    addr_tab[0]  = 32'h1C00_0000; addr_tab[1]  = 32'h1C00_0100;
    addr_tab[2]  = 32'h1C00_0200; addr_tab[3]  = 32'h1C00_0300;
    wdata_tab[0] = 32'h0000_00A0; wdata_tab[1] = 32'hA5A5_A5A5;
    wdata_tab[2] = 32'hC3C3_C3C3; wdata_tab[3] = 32'h3C3C_3C3C;
    be_tab[0] = 4'hF; be_tab[1] = 4'hF; be_tab[2] = 4'h3; be_tab[3] = 4'hC;
    load_payload();
    seq_burst = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    seq_rr    = '{0, 1, 2, 3, 0, 1, 3};

    // Reset state, with every requester asking.
    rst_n  = 1'b0;
    req    = 4'b1111;
    l2_gnt = 1'b1;
    #3;
    check("rst_gnt", gnt4, 4'b0000);
    check("rst_l2req", l2req4, 1'b0);
    check("rst_addr", addr4, 32'h0);
    check("rst_wdata", wdata4, 32'h0);
    check("rst_be", be4, 4'h0);
    check("rst_busy", busy4, 1'b1);

    // Single requester, 1-cycle latency, drain to EMPTY.
    do_reset();
    req = 4'b0010; l2_gnt = 1'b1;
    #2 check("single_gnt", gnt4, 4'b0010);
    next_cycle();
    req = 4'b0000;
    #2;
    check("single_l2req", l2req4, 1'b1);
    check("single_addr", addr4, 32'h1C00_0100);
    check("single_wdata", wdata4, 32'hA5A5_A5A5);
    check("single_be", be4, 4'hF);
    check("single_gnt_off", gnt4, 4'b0000);
    next_cycle();
    #2;
    check("single_empty", l2req4, 1'b0);
    check("single_idle", busy4, 1'b0);

    // L2 grant while EMPTY has no effect.
    next_cycle();
    #2;
    check("empty_gnt_ignored", l2req4, 1'b0);

    // Backpressure: five stalled cycles, then refill on the grant cycle.
    do_reset();
    req = 4'b0001; l2_gnt = 1'b0;
    #2 check("bp_first_gnt", gnt4, 4'b0001);
    next_cycle();
    old_addr = addr_tab[0];
    old_data = wdata_tab[0];
    addr_tab[0]  = 32'h1C00_0040;
    wdata_tab[0] = 32'h5A5A_5A5A;
    load_payload();
    for (int k = 0; k < 5; k++) begin
      #2;
      check("bp_stall_gnt", gnt4, 4'b0000);
      check("bp_stall_req", l2req4, 1'b1);
      check("bp_stall_addr", addr4, old_addr);
      check("bp_stall_data", wdata4, old_data);
      next_cycle();
    end
    l2_gnt = 1'b1;
    #2 check("bp_release_gnt", gnt4, 4'b0001);
    next_cycle();
    req = 4'b0000;
    #2;
    check("bp_new_req", l2req4, 1'b1);
    check("bp_new_addr", addr4, 32'h1C00_0040);
    check("bp_new_data", wdata4, 32'h5A5A_5A5A);
    addr_tab[0]  = old_addr;
    wdata_tab[0] = old_data;
    load_payload();

    // Burst fairness with BURST_MAX=4.
    do_reset();
    req = 4'b0011; l2_gnt = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #2;
      check($sformatf("burst_gnt%0d", k), gnt4, 64'(4'b0001 << seq_burst[k]));
      if (k > 0) check($sformatf("burst_addr%0d", k), addr4, addr_tab[seq_burst[k-1]]);
      next_cycle();
    end

    // Sole requester with BURST_MAX=2: granted every cycle, no bubble.
    do_reset();
    req = 4'b0100; l2_gnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #2;
      check($sformatf("sole_gnt%0d", k), gnt2, 4'b0100);
      if (k > 0) check($sformatf("sole_l2req%0d", k), l2req2, 1'b1);
      next_cycle();
    end

    // Round-robin rotation with BURST_MAX=1, then a sparse request pattern.
    do_reset();
    req = 4'b1111; l2_gnt = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 5) req = 4'b1010;
      #2;
      check($sformatf("rr_gnt%0d", k), gnt1, 64'(4'b0001 << seq_rr[k]));
      next_cycle();
    end

    // Async reset while FULL and stalled drops the transfer immediately.
    do_reset();
    req = 4'b0010; l2_gnt = 1'b0;
    next_cycle();
    req = 4'b0000;
    #2 check("arst_full", l2req4, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_req_drop", l2req4, 1'b0);
    check("arst_addr_zero", addr4, 32'h0);
    req = 4'b1111;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    #2;
    check("arst_first_b4", gnt4, 4'b0001);
    check("arst_first_b1", gnt1, 4'b0001);
    check("arst_no_stale", l2req4, 1'b0);
    next_cycle();
    req = 4'b0000;
    #2;
    check("arst_after_addr", addr4, addr_tab[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
